// File: rtl/lcd_frame_streamer_if.sv
// Byte stream between the frame streamer and the KS0108 LCD controller.
// The streamer presents a column byte with its page/column address; the
// controller accepts it by raising en_tran while data_valid is high.
interface lcd_frame_streamer_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       en_tran;
  logic [2:0] page;
  logic [6:0] col;
  logic       half;

  modport master (
    output data_out,
    output data_valid,
    output page,
    output col,
    output half,
    input  en_tran
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  page,
    input  col,
    input  half,
    output en_tran
  );
endinterface

// File: rtl/lcd_frame_streamer.sv
// Renders the 10x10 game board into the 128x64 KS0108 frame as 1024 column
// bytes (page-major, then column). Each board cell becomes a CELL x CELL pixel
// block inside a fixed window; everything outside the window is blank.
// A redraw request latches the board into a snapshot so that the frame in
// flight never tears; requests arriving mid-frame collapse into one redraw.
module lcd_frame_streamer #(
  parameter int unsigned CELL  = 6,
  parameter int unsigned X_OFF = 34,
  parameter int unsigned Y_OFF = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [99:0]                  game_table,
  input  logic                         change,
  lcd_frame_streamer_if.master         lcd,
  output logic                         frame_busy,
  output logic                         frame_done
);

  localparam logic [7:0] X_LO      = 8'(X_OFF);
  localparam logic [7:0] X_HI      = 8'(X_OFF + 10 * CELL);
  localparam logic [7:0] Y_LO      = 8'(Y_OFF);
  localparam logic [7:0] Y_HI      = 8'(Y_OFF + 10 * CELL);
  localparam logic [7:0] CELL_W    = 8'(CELL);
  localparam logic [7:0] CELL_LAST = 8'(CELL - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [99:0] snapshot_r, snapshot_s;
  logic        pending_r, pending_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic [2:0]  page_r, page_s;
  logic [6:0]  col_r, col_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        last_s;
  logic [6:0]  col_inc_s;
  logic [2:0]  page_inc_s;

  // Column byte for (page, column) of the given board: bit b is pixel y = page*8+b.
  function automatic logic [7:0] column_byte(input logic [99:0] tbl,
                                             input logic [2:0]  pg,
                                             input logic [6:0]  cx);
    logic [7:0] result;
    logic [7:0] xw, yw, dx, dy, mx, my;
    logic [5:0] y;
    logic [3:0] r, c;
    logic [6:0] idx;
    logic       in_x, in_y, gap_ok;
    result = 8'd0;
    xw     = {1'b0, cx};
    in_x   = (xw >= X_LO) && (xw < X_HI);
    dx     = xw - X_LO;
    c      = 4'(dx / CELL_W);
    mx     = dx % CELL_W;
    for (int b = 0; b < 8; b++) begin
      y      = {pg, 3'(b)};
      yw     = {2'b00, y};
      in_y   = (yw >= Y_LO) && (yw < Y_HI);
      dy     = yw - Y_LO;
      r      = 4'(dy / CELL_W);
      my     = dy % CELL_W;
      // Cell index is only meaningful inside the window; the in_x/in_y
      // terms mask whatever the wrapped index selects outside it.
      idx    = 7'd99 - (7'd10 * {3'b000, r}) - {3'b000, c};
      gap_ok = (GAP == 32'd0) || ((mx != CELL_LAST) && (my != CELL_LAST));
      result[b] = in_x && in_y && gap_ok && tbl[idx];
    end
    return result;
  endfunction

  assign last_s     = (page_r == 3'd7) && (col_r == 7'd127);
  assign col_inc_s  = col_r + 7'd1;
  assign page_inc_s = page_r + {2'b00, (col_r == 7'd127)};

  assign lcd.data_out   = data_r;
  assign lcd.data_valid = valid_r;
  assign lcd.page       = page_r;
  assign lcd.col        = col_r;
  assign lcd.half       = col_r[6];
  assign frame_busy     = busy_r;
  assign frame_done     = done_r;

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    snapshot_s = snapshot_r;
    data_s     = data_r;
    valid_s    = valid_r;
    page_s     = page_r;
    col_s      = col_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    // Any request while a frame is in flight is remembered for one redraw.
    if (change && (state_r != ST_IDLE)) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (change) begin
          state_s   = ST_LOAD;
          busy_s    = 1'b1;
          pending_s = 1'b0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The first byte is built from game_table directly, since that is
        // exactly the value the snapshot captures on this same edge.
        snapshot_s = game_table;
        page_s     = 3'd0;
        col_s      = 7'd0;
        data_s     = column_byte(game_table, 3'd0, 7'd0);
        valid_s    = 1'b1;
        state_s    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (lcd.en_tran) begin
          valid_s = 1'b0;
          state_s = ST_ADVANCE;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_ADVANCE: begin
        if (last_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          col_s   = col_inc_s;
          page_s  = page_inc_s;
          data_s  = column_byte(snapshot_r, page_inc_s, col_inc_s);
          valid_s = 1'b1;
          state_s = ST_PRESENT;
        end
      end
      ST_DONE: begin
        // A request landing in this very cycle still gets its redraw.
        pending_s = 1'b0;
        if (pending_r || change) begin
          state_s = ST_LOAD;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        valid_s   = 1'b0;
        busy_s    = 1'b0;
        pending_s = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs; reset returns everything to zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      snapshot_r <= 100'd0;
      pending_r  <= 1'b0;
      data_r     <= 8'd0;
      valid_r    <= 1'b0;
      page_r     <= 3'd0;
      col_r      <= 7'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      snapshot_r <= snapshot_s;
      pending_r  <= pending_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      page_r     <= page_s;
      col_r      <= col_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

endmodule
